serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit full adder over two WIDTH-bit operands, LSB first, one bit per clock. It accepts an operation through a start/ready handshake, runs the carry chain through a registered carry, and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requester (CPU or test sequencer) and the shared full-adder datapath cell, trading area for WIDTH+1 cycles of latency.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- a  in  WIDTH  operand A, sampled on accepted start
- b  in  WIDTH  operand B, sampled on accepted start
- cin  in  1  carry-in, sampled on accepted start
- sub  in  1  subtract select, sampled on accepted start; port exists only with SERIAL_ADD_SUB_EN
- ready  out  1  high in IDLE
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- sum  out  WIDTH  registered result, held until next accepted start completes
- cout  out  1  registered final carry, held with sum

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: ready=1. On start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, → RUN.
- RUN: full adder computes s,c from a_sh[0], b_sh[0], carry. sum_sh shifts right with s entering MSB; a_sh, b_sh shift right; carry<=c; cnt<=cnt+1. When cnt==WIDTH-1 (bit processed this cycle), → DONE.
- DONE entry: sum<=final sum_sh, cout<=final carry. DONE: done=1 for exactly one cycle, → IDLE.
- start while busy=1 is ignored; no queuing.
- sum/cout unchanged during RUN; they update only on entry to DONE.
- cnt width: max(1, clog2(WIDTH)); never wraps (leaves RUN at WIDTH-1).
- WIDTH=1: exactly one RUN cycle.
- Reset mid-operation: state → IDLE, all shift registers, carry, cnt, sum, cout → 0; the operation is discarded, no done.

## Timing
- Reset values: ready=1, busy=0, done=0, sum=0, cout=0.
- Accept at edge E0 (start=1, ready=1). RUN occupies edges E1..E_WIDTH. done=1 between E_WIDTH and E_WIDTH+1. sum/cout valid from E_WIDTH onward. ready returns at E_WIDTH+1.
- Start-to-done latency: WIDTH+1 cycles. Throughput: one operation per WIDTH+2 cycles (back-to-back start held high).
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined: sub port present. On accepted start with sub=1, b_sh<=~b and carry<=1 (cin ignored); result is a−b mod 2^WIDTH, and cout=1 means no borrow. With sub=0, identical to add.
- Undefined: no sub port; add only; cin always used.

## Structure
- Shared package serial_add_pkg: state enum type (IDLE, RUN, DONE), default WIDTH constant, cnt-width function.
- One sub-module: full_adder (combinational, ports A, B, Cin, SUM, CARRY) instantiated once for the bit datapath; everything else lives in serial_add_ctrl.

## Test plan
- WIDTH=8, a=0x3C, b=0x45, cin=0 → done exactly 9 cycles after accept, sum=0x81, cout=0; ready high next cycle.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start held high continuously with three operand sets → one done per 10 cycles; operand changes while busy have no effect on the result.
- Assert rst during RUN cycle 4 → immediately ready=1, busy=0, sum=0, cout=0; no done pulse; next operation 0x01+0x01 → sum=0x02.
- WIDTH=1: a=1, b=1, cin=1 → done 2 cycles after accept, sum=1, cout=1.
- SERIAL_ADD_SUB_EN, WIDTH=8: sub=1, a=0x10, b=0x20 → sum=0xF0, cout=0; sub=1, a=0x20, b=0x10 → sum=0x10, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The bit counter needs at least one bit, even for WIDTH=1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// Requester-side bus of the bit-serial adder.
// Defining SERIAL_ADD_SUB_EN adds the sub select.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  // Handshake: an operation is accepted on a rising clk edge where start=1
  // and ready=1; a/b/cin (and sub) are sampled at that edge only. start while
  // ready=0 is dropped, not queued. done pulses for one cycle when sum/cout
  // become valid; they then hold until the next accepted operation completes.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  state_t           state;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, state
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, state
  );

endinterface

// File: rtl/serial_add_full_adder.sv
// Single-bit full adder cell shared by the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic SUM,
  output logic CARRY
);

  assign SUM   = A ^ B ^ Cin;
  assign CARRY = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, result in WIDTH+1 cycles.
// SERIAL_ADD_SUB_EN enables a-b via inverted B and forced carry-in.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_add_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_nxt, sum_q, b_ld;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, cin_ld, fa_s, fa_c, last;

`ifdef SERIAL_ADD_SUB_EN
  assign b_ld   = bus.sub ? ~bus.b : bus.b;
  assign cin_ld = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_ld   = bus.b;
  assign cin_ld = bus.cin;
`endif

  assign last       = (cnt == CW'(WIDTH - 1));
  assign sum_sh_nxt = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .SUM  (fa_s),
    .CARRY(fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.busy  = (state == RUN) || (state == DONE);
    bus.done  = (state == DONE);
    bus.sum   = sum_q;
    bus.cout  = cout_q;
    bus.state = state;
  end

  // Result registers load on the last RUN edge, i.e. on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= b_ld;
            carry  <= cin_ld;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nxt;
          carry  <= fa_c;
          if (last) begin
            sum_q  <= sum_sh_nxt;
            cout_q <= fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances on one clock.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt8 = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_res = '0;

  serial_add_if #(.WIDTH(8)) if8 ();
  serial_add_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (if8.done) done_cnt8 <= done_cnt8 + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, want end");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation: drive, accept, wait for done, score against exp_q.
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] es, input logic ec);
    int n;
    logic [8:0] e;
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    if8.sub = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom_range(0, 255));
    if8.b = 8'($urandom_range(0, 255));
    if8.cin = 1'($urandom_range(0, 1));
    exp_q.push_back({ec, es});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 4) check_eq({tag, "_hold"}, {if8.cout, if8.sum}, last_res);
    end while (!if8.done && n < 40);
    check_eq({tag, "_lat"}, n, 9);
    e = exp_q.pop_front();
    check_eq({tag, "_res"}, {if8.cout, if8.sum}, e);
    last_res = e;
    @(negedge clk);
    check_eq({tag, "_rdy"}, {if8.ready, if8.done}, 2'b10);
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  initial begin
    vec_t b2b [3];
    int   n;
    int   t_prev;
    logic [8:0] e;
    b2b[0] = '{a: 8'h12, b: 8'h34, cin: 1'b0, es: 8'h46, ec: 1'b0};
    b2b[1] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, es: 8'h00, ec: 1'b1};
    b2b[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, es: 8'h80, ec: 1'b0};

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    if8.sub = 1'b0; if1.sub = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check_eq("rst_ready", if8.ready, 1'b1);
    check_eq("rst_busy", if8.busy, 1'b0);
    check_eq("rst_done", if8.done, 1'b0);
    check_eq("rst_sum", if8.sum, 8'h00);
    check_eq("rst_cout", if8.cout, 1'b0);
    check_eq("rst_ready1", if1.ready, 1'b1);
    rst = 1'b0;

    // directed add vectors
    run_op8("add_3c_45", 8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0);
    run_op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // start held high: one result per WIDTH+2 cycles, busy-time operand noise ignored
    @(negedge clk);
    if8.start = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      if8.a = b2b[k].a; if8.b = b2b[k].b; if8.cin = b2b[k].cin;
      exp_q.push_back({b2b[k].ec, b2b[k].es});
      @(posedge clk);
      #1;
      if8.a = 8'($urandom_range(0, 255));
      if8.b = 8'($urandom_range(0, 255));
      if8.cin = 1'($urandom_range(0, 1));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if8.done && n < 40);
      check_eq($sformatf("b2b%0d_lat", k), n, 9);
      e = exp_q.pop_front();
      check_eq($sformatf("b2b%0d_res", k), {if8.cout, if8.sum}, e);
      last_res = e;
      if (k > 0) check_eq($sformatf("b2b%0d_period", k), cyc - t_prev, 10);
      t_prev = cyc;
      @(negedge clk);
      check_eq($sformatf("b2b%0d_rdy", k), {if8.ready, if8.done}, 2'b10);
      if (k == 2) if8.start = 1'b0;
    end

    // reset in RUN cycle 4 discards the operation
    @(negedge clk);
    if8.a = 8'h3C; if8.b = 8'h45; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_ready", if8.ready, 1'b1);
    check_eq("mrst_busy", if8.busy, 1'b0);
    check_eq("mrst_sum", if8.sum, 8'h00);
    check_eq("mrst_cout", if8.cout, 1'b0);
    n = done_cnt8;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    repeat (12) @(negedge clk);
    check_eq("mrst_nodone", done_cnt8 - n, 0);
    run_op8("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // WIDTH=1 instance
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.start = 1'b1;
    @(posedge clk);
    #1 if1.start = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if1.done && n < 20);
    check_eq("w1_lat", n, 2);
    check_eq("w1_res", {if1.cout, if1.sum}, 2'b11);
    @(negedge clk);
    check_eq("w1_rdy", {if1.ready, if1.done}, 2'b10);

`ifdef SERIAL_ADD_SUB_EN
    run_op8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0);
    run_op8("sub_20_10", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1);
    run_op8("sub0_add", 8'h20, 8'h10, 1'b1, 1'b0, 8'h31, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
